// File: rtl/alu_mdu_if.sv
// Issue/result bundle between the issuing stage and the alu_mdu execute block.
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic             valid_out;
  logic [WIDTH-1:0] result;
  logic             cond_true;
  logic             overflow;
  logic             invalid_op;
  logic             busy;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output valid_in, alu_ctrl, a, b, shamt,
    input  ready_out, valid_out, result, cond_true, overflow, invalid_op, busy, hi_out, lo_out
  );

  modport slave (
    input  valid_in, alu_ctrl, a, b, shamt,
    output ready_out, valid_out, result, cond_true, overflow, invalid_op, busy, hi_out, lo_out
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with single-cycle ops and an iterative shift-add
// multiplier that owns the HI/LO pair.
module alu_mdu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave bus
);
  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [W2-1:0]    r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [W2-1:0]    r_acc, w_acc_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_madd, w_madd_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_cond, w_cond_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_inv, w_inv_nxt;

  logic [WIDTH-1:0] w_a, w_b, w_sum, w_dif, w_res, w_abs_a, w_abs_b;
  logic             w_cond, w_ovf, w_inv, w_mul, w_cmp, w_signed;
  logic             w_slt, w_sgt, w_ult, w_ugt, w_eq;
  logic [W2-1:0]    w_prod, w_hilo;

  assign w_a   = bus.a;
  assign w_b   = bus.b;
  assign w_sum = w_a + w_b;
  assign w_dif = w_a - w_b;
  assign w_slt = $signed(w_a) < $signed(w_b);
  assign w_sgt = $signed(w_b) < $signed(w_a);
  assign w_ult = w_a < w_b;
  assign w_ugt = w_b < w_a;
  assign w_eq  = (w_a == w_b);

  // Signed multiplies iterate on magnitudes; the sign is reapplied in DONE.
  assign w_signed = ~bus.alu_ctrl[0];
  assign w_abs_a  = (w_signed && w_a[MSB]) ? (~w_a + WIDTH'(1)) : w_a;
  assign w_abs_b  = (w_signed && w_b[MSB]) ? (~w_b + WIDTH'(1)) : w_b;
  assign w_prod   = r_neg ? (~r_acc + W2'(1)) : r_acc;
  assign w_hilo   = r_madd ? ({r_hi, r_lo} + w_prod) : w_prod;

  always_comb begin : alu_decode
    w_res  = '0;
    w_cond = 1'b0;
    w_ovf  = 1'b0;
    w_inv  = 1'b0;
    w_mul  = 1'b0;
    w_cmp  = 1'b0;
    case (bus.alu_ctrl)
      6'b100000: begin
        w_res = w_sum;
        w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
      6'b100001: w_res = w_sum;
      6'b100010: begin
        w_res = w_dif;
        w_ovf = (w_a[MSB] != w_b[MSB]) && (w_dif[MSB] != w_a[MSB]);
      end
      6'b100011: w_res = w_dif;
      6'b100100: w_res = w_a & w_b;
      6'b100101: w_res = w_a | w_b;
      6'b100110: w_res = w_a ^ w_b;
      6'b100111: w_res = ~(w_a | w_b);
      6'b101000: w_res = ~w_a;
      6'b000000: w_res = w_b << bus.shamt;
      6'b000010: w_res = w_b >> bus.shamt;
      6'b000011: w_res = WIDTH'($signed(w_b) >>> bus.shamt);
      6'b101010: begin w_cmp = 1'b1; w_cond = w_slt;  end
      6'b101011: begin w_cmp = 1'b1; w_cond = w_ult;  end
      6'b101100: begin w_cmp = 1'b1; w_cond = w_eq;   end
      6'b101101: begin w_cmp = 1'b1; w_cond = !w_eq;  end
      6'b101110: begin w_cmp = 1'b1; w_cond = w_sgt;  end
      6'b101111: begin w_cmp = 1'b1; w_cond = !w_slt; end
      6'b110000: begin w_cmp = 1'b1; w_cond = w_slt;  end
      6'b110001: begin w_cmp = 1'b1; w_cond = !w_sgt; end
      6'b110010: begin w_cmp = 1'b1; w_cond = !w_ugt; end
      6'b110011: begin w_cmp = 1'b1; w_cond = w_ugt;  end
      6'b001000: w_res = w_a;
      6'b010000: w_res = r_hi;
      6'b010010: w_res = r_lo;
      6'b011000, 6'b011001, 6'b011100, 6'b011101: w_mul = 1'b1;
      default:   w_inv = 1'b1;
    endcase
    if (w_cmp) w_res = WIDTH'(w_cond);
  end

  always_comb begin : fsm_next
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_neg_nxt    = r_neg;
    w_madd_nxt   = r_madd;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_result_nxt = r_result;
    w_cond_nxt   = r_cond;
    w_ovf_nxt    = r_ovf;
    w_inv_nxt    = r_inv;
    w_valid_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.valid_in) begin
          if (w_mul) begin
            w_state_nxt  = ST_MUL;
            w_cnt_nxt    = '0;
            w_mcand_nxt  = W2'(w_abs_a);
            w_mplier_nxt = w_abs_b;
            w_acc_nxt    = '0;
            w_neg_nxt    = w_signed && (w_a[MSB] ^ w_b[MSB]);
            w_madd_nxt   = bus.alu_ctrl[2];
          end else begin
            w_result_nxt = w_res;
            w_cond_nxt   = w_cond;
            w_ovf_nxt    = w_ovf;
            w_inv_nxt    = w_inv;
            w_valid_nxt  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        if (r_cnt == CW'(MUL_CYCLES - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_hi_nxt     = w_hilo[W2-1:WIDTH];
        w_lo_nxt     = w_hilo[WIDTH-1:0];
        w_result_nxt = w_hilo[WIDTH-1:0];
        w_cond_nxt   = 1'b0;
        w_ovf_nxt    = 1'b0;
        w_inv_nxt    = 1'b0;
        w_valid_nxt  = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_madd   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_cond   <= 1'b0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_neg    <= w_neg_nxt;
      r_madd   <= w_madd_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_result <= w_result_nxt;
      r_valid  <= w_valid_nxt;
      r_cond   <= w_cond_nxt;
      r_ovf    <= w_ovf_nxt;
      r_inv    <= w_inv_nxt;
    end
  end

  assign bus.ready_out  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.valid_out  = r_valid;
  assign bus.result     = r_result;
  assign bus.cond_true  = r_cond;
  assign bus.overflow   = r_ovf;
  assign bus.invalid_op = r_inv;
  assign bus.hi_out     = r_hi;
  assign bus.lo_out     = r_lo;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_mdu_if #(.WIDTH(32)) bus ();

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADD = 6'b100000, OP_ADDU = 6'b100001, OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010, OP_SLTU = 6'b101011, OP_SRA = 6'b000011;
  localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MADD = 6'b011100, OP_MADDU = 6'b011101;
  localparam logic [5:0] OP_MFHI = 6'b010000, OP_MFLO = 6'b010010;

  logic [5:0] sc_codes [0:24] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h28, 6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h2C, 6'h2D,
                                  6'h2E, 6'h2F, 6'h30, 6'h31, 6'h32, 6'h33, 6'h08, 6'h10, 6'h12};
  logic [31:0] edge_vals [0:4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};

  function automatic void ref_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic cnd,
                                 output logic ov, output logic inv);
    longint sa, sb, ua, ub, s;
    logic is_cmp;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    r = '0; cnd = 1'b0; ov = 1'b0; inv = 1'b0; is_cmp = 1'b1;
    case (c)
      6'h2A, 6'h30: cnd = (sa < sb);
      6'h2B:        cnd = (ua < ub);
      6'h2C:        cnd = (a == b);
      6'h2D:        cnd = (a != b);
      6'h2E:        cnd = (sa > sb);
      6'h2F:        cnd = (sa >= sb);
      6'h31:        cnd = (sa <= sb);
      6'h32:        cnd = (ua <= ub);
      6'h33:        cnd = (ua > ub);
      default:      is_cmp = 1'b0;
    endcase
    if (is_cmp) begin
      r = {31'd0, cnd};
    end else begin
      case (c)
        6'h20: begin s = sa + sb; r = 32'(s); ov = (s != longint'($signed(r))); end
        6'h21: r = 32'(ua + ub);
        6'h22: begin s = sa - sb; r = 32'(s); ov = (s != longint'($signed(r))); end
        6'h23: r = 32'(ua - ub);
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h28: r = ~a;
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: r = (b >> sh) | (b[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
        6'h08: r = a;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        default: inv = 1'b1;
      endcase
    end
  endfunction

  function automatic void model_mul(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (c[0]) p = 64'(a) * 64'(b);
    else      p = 64'(longint'($signed(a)) * longint'($signed(b)));
    if (c[2]) {m_hi, m_lo} = {m_hi, m_lo} + p;
    else      {m_hi, m_lo} = p;
  endfunction

  task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.alu_ctrl = c; bus.a = a; bus.b = b; bus.shamt = sh;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic run_mul(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    send(c, a, b, 5'd0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid_out) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", bus.result); end
    checks++; if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.cond_true !== 1'b0 ||
                  bus.overflow !== 1'b0 || bus.invalid_op !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v%b b%b c%b o%b i%b exp 0", bus.valid_out, bus.busy,
                         bus.cond_true, bus.overflow, bus.invalid_op); end
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.ready_out); end
    checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got %h_%h exp 0", bus.hi_out, bus.lo_out); end
  endtask

  task automatic test_arith();
    logic [5:0]  c [0:2] = '{OP_ADD, OP_ADDU, OP_SUB};
    logic [31:0] a [0:2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] er [0:2] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic        eo [0:2] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(c[i], a[i], 32'h1, 5'd0);
      checks++; if (bus.valid_out !== 1'b1 || bus.result !== er[i]) begin
        errors++; $display("FAIL arith_result[%0d]: got v%b %h exp v1 %h", i, bus.valid_out, bus.result, er[i]); end
      checks++; if (bus.overflow !== eo[i]) begin
        errors++; $display("FAIL arith_ovf[%0d]: got %b exp %b", i, bus.overflow, eo[i]); end
    end
    @(posedge clk); #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b exp 0", bus.valid_out); end
  endtask

  task automatic test_random_single(input int n);
    logic [5:0] c; logic [31:0] a, b, er; logic [4:0] sh; logic ec, eo, ei;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) c = 6'($urandom_range(0, 63));
      else c = sc_codes[$urandom_range(0, 24)];
      if (c inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU}) c = 6'h3F;
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      sh = 5'($urandom_range(0, 31));
      ref_op(c, a, b, sh, er, ec, eo, ei);
      send(c, a, b, sh);
      checks++; if (bus.valid_out !== 1'b1 || bus.result !== er || bus.cond_true !== ec ||
                    bus.overflow !== eo || bus.invalid_op !== ei) begin
        errors++; $display("FAIL rand_op %h a=%h b=%h sh=%0d: got v%b r=%h c%b o%b i%b exp v1 r=%h c%b o%b i%b",
                           c, a, b, sh, bus.valid_out, bus.result, bus.cond_true, bus.overflow,
                           bus.invalid_op, er, ec, eo, ei); end
      checks++; if (bus.hi_out !== m_hi || bus.lo_out !== m_lo) begin
        errors++; $display("FAIL rand_hilo: got %h_%h exp %h_%h", bus.hi_out, bus.lo_out, m_hi, m_lo); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  c [0:2] = '{OP_SLT, OP_SLTU, OP_SRA};
    logic [31:0] a [0:2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] b [0:2] = '{32'h1, 32'h1, 32'h80000000};
    logic [4:0]  s [0:2] = '{5'd0, 5'd0, 5'd4};
    logic [31:0] er [0:2] = '{32'h1, 32'h0, 32'hF8000000};
    logic        ec [0:2] = '{1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.valid_in = 1'b1; bus.alu_ctrl = c[i]; bus.a = a[i]; bus.b = b[i]; bus.shamt = s[i];
      @(posedge clk); #1;
      checks++; if (bus.valid_out !== 1'b1 || bus.result !== er[i] || bus.cond_true !== ec[i]) begin
        errors++; $display("FAIL b2b[%0d]: got v%b r=%h c%b exp v1 r=%h c%b", i, bus.valid_out,
                           bus.result, bus.cond_true, er[i], ec[i]); end
    end
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b exp 0", bus.valid_out); end
  endtask

  task automatic test_mult();
    int low, lat;
    model_mul(OP_MULT, 32'hFFFFFFFD, 32'h7);
    send(OP_MULT, 32'hFFFFFFFD, 32'h7, 5'd0);
    low = bus.ready_out ? 0 : 1;
    bus.valid_in = 1'b1; bus.alu_ctrl = OP_ADD; bus.a = 32'h1; bus.b = 32'h1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid_out) begin lat = k; break; end
      if (!bus.ready_out) low++;
    end
    bus.valid_in = 1'b0;
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d exp 33", lat); end
    checks++; if (low != 33) begin errors++; $display("FAIL mult_ready_low: got %0d exp 33", low); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFF || bus.lo_out !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_hilo: got %h_%h exp ffffffff_ffffffeb", bus.hi_out, bus.lo_out); end
    checks++; if (bus.result !== 32'hFFFFFFEB || bus.ready_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mult_done: got r=%h rdy%b busy%b exp ffffffeb 1 0", bus.result,
                         bus.ready_out, bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mult_single_pulse: got %b exp 0", bus.valid_out); end
  endtask

  task automatic test_madd();
    int lat;
    model_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++; if (bus.hi_out !== 32'hFFFFFFFE || bus.lo_out !== 32'h1) begin
      errors++; $display("FAIL multu_hilo: got %h_%h exp fffffffe_00000001", bus.hi_out, bus.lo_out); end
    model_mul(OP_MADDU, 32'h2, 32'h3);
    run_mul(OP_MADDU, 32'h2, 32'h3, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL maddu_latency: got %0d exp 33", lat); end
    checks++; if (bus.hi_out !== 32'hFFFFFFFE || bus.lo_out !== 32'h7 || bus.result !== 32'h7) begin
      errors++; $display("FAIL maddu_hilo: got %h_%h r=%h exp fffffffe_00000007 r=7", bus.hi_out,
                         bus.lo_out, bus.result); end
    send(OP_MFHI, 32'h0, 32'h0, 5'd0);
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mfhi: got %h exp fffffffe", bus.result); end
    send(OP_MFLO, 32'h0, 32'h0, 5'd0);
    checks++; if (bus.result !== 32'h7) begin errors++; $display("FAIL mflo: got %h exp 00000007", bus.result); end
  endtask

  task automatic test_random_mul(input int n);
    int lat; logic [5:0] c; logic [31:0] a, b;
    logic [5:0] mc [0:3] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
    model_mul(OP_MULT, 32'h80000000, 32'h80000000);
    run_mul(OP_MULT, 32'h80000000, 32'h80000000, lat);
    checks++; if (bus.hi_out !== 32'h40000000 || bus.lo_out !== 32'h0) begin
      errors++; $display("FAIL mult_minneg: got %h_%h exp 40000000_00000000", bus.hi_out, bus.lo_out); end
    for (int i = 0; i < n; i++) begin
      c = mc[$urandom_range(0, 3)];
      a = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      b = $urandom;
      model_mul(c, a, b);
      run_mul(c, a, b, lat);
      checks++; if (lat != 33 || bus.hi_out !== m_hi || bus.lo_out !== m_lo || bus.result !== m_lo) begin
        errors++; $display("FAIL rand_mul %h a=%h b=%h: got lat=%0d %h_%h r=%h exp lat=33 %h_%h",
                           c, a, b, lat, bus.hi_out, bus.lo_out, bus.result, m_hi, m_lo); end
    end
  endtask

  task automatic test_branch();
    logic [5:0] c [0:3] = '{6'b101110, 6'b110011, 6'b101101, 6'b101100};
    logic       ec [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(c[i], 32'h5, 32'hFFFFFFFB, 5'd0);
      checks++; if (bus.cond_true !== ec[i] || bus.result !== {31'd0, ec[i]}) begin
        errors++; $display("FAIL branch %b: got c%b r=%h exp c%b", c[i], bus.cond_true, bus.result, ec[i]); end
    end
    send(6'b111111, 32'h5, 32'hFFFFFFFB, 5'd0);
    checks++; if (bus.invalid_op !== 1'b1 || bus.result !== 32'h0 || bus.valid_out !== 1'b1) begin
      errors++; $display("FAIL invalid_op: got i%b r=%h v%b exp i1 r=0 v1", bus.invalid_op, bus.result, bus.valid_out); end
    checks++; if (bus.hi_out !== m_hi || bus.lo_out !== m_lo || bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL invalid_state: got %h_%h rdy%b exp %h_%h rdy1", bus.hi_out, bus.lo_out,
                         bus.ready_out, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    send(OP_MULT, 32'hFFFFFFFD, 32'h7, 5'd0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.busy !== 1'b0 ||
                  bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_mul: got %h_%h busy%b rdy%b v%b exp 0_0 0 1 0", bus.hi_out,
                         bus.lo_out, bus.busy, bus.ready_out, bus.valid_out); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid_out) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL aborted_mul_pulse: got %0d exp 0", pulses); end
    send(OP_ADD, 32'h1, 32'h2, 5'd0);
    checks++; if (bus.valid_out !== 1'b1 || bus.result !== 32'h3) begin
      errors++; $display("FAIL add_after_reset: got v%b %h exp v1 00000003", bus.valid_out, bus.result); end
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.alu_ctrl = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_arith();
    test_random_single(80);
    test_back_to_back();
    test_mult();
    test_madd();
    test_random_single(30);
    test_random_mul(8);
    test_branch();
    test_reset_mid_mul();
    test_random_single(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Execute-stage datapath that consumes the 6-bit ALU operation code produced by the ALU control decoder.
- Single-cycle ops (add/sub, logic, shifts, compares, branch conditions) have a registered result one cycle after acceptance.
- MULT/MULTU/MADD/MADDU run on an iterative shift-add multiplier and update the HI/LO pair. MFHI/MFLO read HI/LO.
- A valid/ready handshake stalls the issuing stage while a multiply is in flight.

Parameters:
WIDTH, 32, operand/result width; HI and LO are each WIDTH bits
MUL_CYCLES, 32, multiplier iterations (one multiplier bit per cycle); must equal WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  operation presented this cycle
ready_out  output  1  block can accept; an op is accepted when valid_in && ready_out at a clk edge
alu_ctrl  input  6  operation code from ALU control
a  input  WIDTH  rs operand
b  input  WIDTH  rt operand or immediate
shamt  input  5  shift amount
valid_out  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  registered result
cond_true  output  1  compare/branch outcome, registered with result
overflow  output  1  signed overflow on ADD (100000) or SUB (100010)
invalid_op  output  1  unrecognised alu_ctrl
busy  output  1  multiply in progress
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, HI, LO, iteration counter = 0; valid_out, cond_true, overflow, invalid_op, busy = 0; ready_out = 1. Reset mid-multiply aborts the op with no valid_out and clears HI/LO.
- FSM IDLE -> MUL -> DONE -> IDLE. ready_out = (state==IDLE); busy = (state!=IDLE). valid_in while not ready is ignored.
- Single-cycle ops, accepted at edge N: result, flags and valid_out=1 are registered at N. They are visible during cycle N+1 and valid_out drops next edge unless a new op is accepted. Back-to-back accepts are allowed every cycle.
- Arithmetic and logic:
  - 100000 ADD, 100001 ADDU: a+b mod 2^WIDTH. ADD sets overflow when the operands have the same sign and the result sign differs.
  - 100010 SUB, 100011 SUBU: a-b. SUB sets overflow when the operand signs differ and the result sign differs from a.
  - Overflow never suppresses the result.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR; 101000 NOT gives ~a.
- Shifts, applied to b by shamt: 000000 SLL, 000010 SRL (logical), 000011 SRA (arithmetic).
- Set ops: 101010 SLT (signed), 101011 SLTU (unsigned). result = {0…,a<b}; cond_true equals the same bit.
- Conditions, with result = {0…,cond_true}:
  - 101100 a==b; 101101 a!=b
  - 101110 a>b signed; 101111 a>=b signed
  - 110000 a<b signed; 110001 a<=b signed
  - 110010 a<=b unsigned; 110011 a>b unsigned
- 001000 JR: result=a. 010000 MFHI: result=HI. 010010 MFLO: result=LO.
- Any other code, including 111111: result=0 and invalid_op=1 with valid_out. State, HI and LO are unchanged.
- Flags not defined for an op read 0.
- Multiply entry: 011000 MULT, 011001 MULTU, 011100 MADD, 011101 MADDU go to MUL.
  - Latch the operands and the op.
  - For signed ops, latch |a| and |b| and a negate flag (sign(a) XOR sign(b)).
- MUL: one shift-add per edge, counter 0..MUL_CYCLES-1, 2*WIDTH-bit unsigned accumulator. After the last iteration go to DONE.
- DONE, one edge:
  - P = accumulator, two's-complement negated if the negate flag is set (the most negative operand is handled correctly, e.g. 0x80000000*0x80000000 = 0x40000000_00000000).
  - MULT/MULTU: {HI,LO}=P. MADD/MADDU: {HI,LO}={HI,LO}+P mod 2^(2*WIDTH).
  - result = new LO; valid_out=1; return to IDLE.
- Multiply latency: accept at edge N gives valid_out during cycle N+MUL_CYCLES+1 (cycle N+33 at the defaults). ready_out returns high in that same cycle.
- HI/LO change only in DONE or on reset. MFHI/MFLO issued right after a multiply read the updated values, because acceptance is blocked until DONE has completed.

Test Plan:
- Reset asserted mid-MULT at iteration 10 -> HI=LO=0, busy=0, ready_out=1, no valid_out pulse; an ADD 1+2 next gives result=3 one cycle after accept.
- ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1; ADDU with the same operands -> overflow=0; SUB 0x80000000-1 -> result=0x7FFFFFFF, overflow=1.
- Back-to-back single-cycle ops (SLT a=-1,b=1; SLTU same operands; SRA b=0x80000000 shamt=4) -> valid_out high three consecutive cycles with results 1, 0, 0xF8000000; cond_true 1, 0, 0.
- MULT a=-3,b=7 -> ready_out low for MUL_CYCLES+1 cycles, valid_out exactly 33 cycles after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB; valid_in held during busy is ignored.
- MULTU 0xFFFFFFFF*0xFFFFFFFF then MADDU 2*3 then MFHI and MFLO -> HI=0xFFFFFFFE, LO=0x00000007 after MADDU; MFHI result=0xFFFFFFFE, MFLO result=0x00000007.
- Branch codes with a=5, b=0xFFFFFFFB: 101110 cond=1, 110011 cond=0, 101101 cond=1, 101100 cond=0; alu_ctrl=111111 -> invalid_op=1, result=0, HI/LO unchanged.
